// File: rtl/obi_periph_arb.sv
// Round-robin arbiter sharing one OBI peripheral slave port among NUM_REQ masters.
// Optional response timeout enabled by defining OBI_PERIPH_ARB_TIMEOUT_EN.
module obi_periph_arb #(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_REQ-1:0]      m_req_i,
   input  logic [NUM_REQ-1:0]      m_we_i,
   input  logic [4*NUM_REQ-1:0]    m_be_i,
   input  logic [32*NUM_REQ-1:0]   m_addr_i,
   input  logic [32*NUM_REQ-1:0]   m_wdata_i,
   output logic [NUM_REQ-1:0]      m_gnt_o,
   output logic [NUM_REQ-1:0]      m_rvalid_o,
   output logic [31:0]             m_rdata_o,
   output logic                    s_req_o,
   output logic                    s_we_o,
   output logic [3:0]              s_be_o,
   output logic [31:0]             s_addr_o,
   output logic [31:0]             s_wdata_o,
   input  logic                    s_gnt_i,
   input  logic                    s_rvalid_i,
   input  logic [31:0]             s_rdata_i,
   output logic                    busy_o,
   output logic                    timeout_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_chk
      $error("obi_periph_arb: parameter out of range");
   end

   typedef enum logic {IDLE, WAIT_RSP} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] cand;
   logic             any_req;
   logic             arb_en;
   logic             accept;
   logic             tmo;

   // Walk the masters starting just after the last winner; first requester wins.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
      cand    = last_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (cand == IDX_W'(NUM_REQ-1)) ? '0 : cand + 1'b1;
         if (!any_req && m_req_i[cand]) begin
            win     = cand;
            any_req = 1'b1;
         end
      end
   end

`ifdef OBI_PERIPH_ARB_TIMEOUT_EN
   logic [15:0] cnt_q;
   assign tmo = (state_q == WAIT_RSP) && !s_rvalid_i && ((cnt_q + 16'd1) == 16'(TIMEOUT_CYC));
`else
   assign tmo = 1'b0;
`endif

   // A new request may be issued when idle or in the cycle the response returns.
   assign arb_en  = !rst_i && ((state_q == IDLE) || s_rvalid_i);
   assign s_req_o = arb_en && any_req;
   assign accept  = s_req_o && s_gnt_i;

   assign s_we_o    = s_req_o ? m_we_i[win]              : 1'b0;
   assign s_be_o    = s_req_o ? m_be_i[4*win +: 4]       : 4'h0;
   assign s_addr_o  = s_req_o ? m_addr_i[32*win +: 32]   : 32'h0;
   assign s_wdata_o = s_req_o ? m_wdata_i[32*win +: 32]  : 32'h0;

   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      if (accept)
         m_gnt_o[win] = 1'b1;
      if (!rst_i && (state_q == WAIT_RSP) && (s_rvalid_i || tmo))
         m_rvalid_o[owner_q] = 1'b1;
   end

   assign m_rdata_o = rst_i      ? 32'h0 :
                      s_rvalid_i ? s_rdata_i :
                      tmo        ? 32'hDEAD_BEEF : 32'h0;

   assign busy_o    = !rst_i && (state_q == WAIT_RSP);
   assign timeout_o = !rst_i && tmo;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= IDX_W'(NUM_REQ-1);
         owner_q <= '0;
`ifdef OBI_PERIPH_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else if (accept) begin
         state_q <= WAIT_RSP;
         owner_q <= win;
         last_q  <= win;
`ifdef OBI_PERIPH_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else if ((state_q == WAIT_RSP) && (s_rvalid_i || tmo)) begin
         state_q <= IDLE;
      end else if (state_q == WAIT_RSP) begin
`ifdef OBI_PERIPH_ARB_TIMEOUT_EN
         cnt_q   <= cnt_q + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_obi_periph_arb.sv
// Directed bench for obi_periph_arb (NUM_REQ=2) with a response-routing scoreboard.
module tb_obi_periph_arb;
   localparam int N    = 2;
   localparam int TCYC = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_we;
   logic [4*N-1:0]  m_be;
   logic [32*N-1:0] m_addr;
   logic [32*N-1:0] m_wdata;
   logic [N-1:0]    m_gnt;
   logic [N-1:0]    m_rvalid;
   logic [31:0]     m_rdata;
   logic            s_req, s_we;
   logic [3:0]      s_be;
   logic [31:0]     s_addr, s_wdata;
   logic            s_gnt, s_rvalid;
   logic [31:0]     s_rdata;
   logic            busy, tmo;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   assign m_addr  = {32'h0000_0020, 32'h0000_0010};
   assign m_we    = 2'b10;
   assign m_be    = {4'h3, 4'hF};
   assign m_wdata = {32'hA5A5_0001, 32'h0000_0000};

   obi_periph_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TCYC)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
      .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
      .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .busy_o(busy), .timeout_o(tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rst_cyc(input string tag);
      @(negedge clk);
      rst = 1'b1; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF;
      #1;
      chk({tag, " gnt"},    32'(m_gnt), 32'h0);
      chk({tag, " rvalid"}, 32'(m_rvalid), 32'h0);
      chk({tag, " rdata"},  m_rdata, 32'h0);
      chk({tag, " sreq"},   32'({s_req, s_we, s_be}), 32'h0);
      chk({tag, " saddr"},  s_addr | s_wdata, 32'h0);
      chk({tag, " busy"},   32'({busy, tmo}), 32'h0);
      exp_q.delete();
   endtask

   // One bus cycle: drive, then check grant, busy and any response against the scoreboard.
   task automatic cyc(input string tag, input logic [1:0] req, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic [1:0] exp_gnt, input logic exp_busy);
      int m;
      @(negedge clk);
      rst = 1'b0; m_req = req; s_gnt = gnt; s_rvalid = rv; s_rdata = rd;
      #1;
      chk({tag, " gnt"},  32'(m_gnt), 32'(exp_gnt));
      chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, " tmo"},  32'(tmo), 32'h0);
      if (rv && exp_q.size() > 0) begin
         m = exp_q.pop_front();
         chk({tag, " rvalid"}, 32'(m_rvalid), 32'd1 << m);
         chk({tag, " rdata"},  m_rdata, rd);
      end else begin
         chk({tag, " rvalid"}, 32'(m_rvalid), 32'h0);
      end
      if (exp_gnt != 2'b00) begin
         m = exp_gnt[1] ? 1 : 0;
         exp_q.push_back(m);
         chk({tag, " saddr"}, s_addr, (m == 1) ? 32'h0000_0020 : 32'h0000_0010);
      end
   endtask

   initial begin
      rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      rst_cyc("reset0");
      rst_cyc("reset1");

      // single master read
      cyc("t1 req", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0);
      chk("t1 we", 32'({s_we, s_be}), 32'h0F);
      cyc("t1 rsp", 2'b00, 1'b1, 1'b1, 32'h1234_5678, 2'b00, 1'b1);
      cyc("t1 idle", 2'b00, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);

      // both masters continuously from reset, back-to-back
      rst_cyc("reset2");
      cyc("t2 c0", 2'b11, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0);
      cyc("t2 c1", 2'b11, 1'b1, 1'b1, 32'hAAAA_0001, 2'b10, 1'b1);
      cyc("t2 c2", 2'b11, 1'b1, 1'b1, 32'hAAAA_0002, 2'b01, 1'b1);
      cyc("t2 c3", 2'b11, 1'b1, 1'b1, 32'hAAAA_0003, 2'b10, 1'b1);
      cyc("t2 c4", 2'b00, 1'b1, 1'b1, 32'hAAAA_0004, 2'b00, 1'b1);
      cyc("t2 c5", 2'b00, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);

      // slave stalls grant for 3 cycles while m1 requests
      for (int i = 0; i < 3; i++) begin
         cyc("t3 stall", 2'b10, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
         chk("t3 sreq", 32'({s_req, s_we, s_be}), 32'h33);
         chk("t3 swdata", s_wdata, 32'hA5A5_0001);
         chk("t3 saddr", s_addr, 32'h0000_0020);
      end
      cyc("t3 gnt", 2'b10, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0);
      cyc("t3 rsp", 2'b00, 1'b1, 1'b1, 32'h5555_0003, 2'b00, 1'b1);
      cyc("t3 stray", 2'b00, 1'b0, 1'b1, 32'h6666_0000, 2'b00, 1'b0);
      chk("t3 sidle", 32'({s_req, s_we, s_be}) | s_addr | s_wdata, 32'h0);

      // reset during WAIT_RSP
      cyc("t5 gnt", 2'b10, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0);
      rst_cyc("t5 rst0");
      rst_cyc("t5 rst1");
      cyc("t5 late", 2'b11, 1'b1, 1'b1, 32'hBAD0_0000, 2'b01, 1'b0);
      cyc("t5 rsp", 2'b00, 1'b1, 1'b1, 32'h0000_0005, 2'b00, 1'b1);
      cyc("t5 idle", 2'b00, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);

`ifdef OBI_PERIPH_ARB_TIMEOUT_EN
      // slave never answers
      cyc("t4 gnt", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0);
      for (int i = 1; i < TCYC; i++)
         cyc("t4 wait", 2'b00, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
      @(negedge clk);
      m_req = 2'b00; s_gnt = 1'b1; s_rvalid = 1'b0; s_rdata = 32'h0;
      #1;
      begin
         int m;
         m = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
         chk("t4 rvalid", 32'(m_rvalid), 32'd1 << m);
      end
      chk("t4 rdata", m_rdata, 32'hDEAD_BEEF);
      chk("t4 tmo", 32'(tmo), 32'h1);
      chk("t4 busy", 32'(busy), 32'h1);
      cyc("t4 stray", 2'b00, 1'b0, 1'b1, 32'h7777_0000, 2'b00, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
